// File: rtl/pagerank_mem_arbiter.sv
// Round-robin arbiter sharing one test-memory port among NREQ pageRank requesters,
// tagging requests with the requester index and routing responses back by that tag.
// Optional PAGERANK_MEM_ARB_PERF_EN adds grant_cnt/stall_cnt performance counters.
module pagerank_mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ*77-1:0]   req_msg,
    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      req_rdy,
    output logic [NREQ*47-1:0]   resp_msg,
    output logic [NREQ-1:0]      resp_val,
    input  logic [NREQ-1:0]      resp_rdy,
    output logic [76:0]          mem_req_msg,
    output logic                 mem_req_val,
    input  logic                 mem_req_rdy,
    input  logic [46:0]          mem_resp_msg,
    input  logic                 mem_resp_val,
    output logic                 mem_resp_rdy,
    output logic                 tag_err
`ifdef PAGERANK_MEM_ARB_PERF_EN
    ,
    output logic [31:0]          grant_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] ptr;
    logic [76:0]   qreg;
    logic          q_val;
    logic [3:0]    out_cnt;
    logic [46:0]   rreg;
    logic          r_val;
    logic [IW-1:0] r_dest;

    logic          mem_fire;
    logic [4:0]    inflight;
    logic          can_accept;
    logic [IW-1:0] grant;
    logic          any_val;
    int            scan_idx;
    logic          req_fire;
    logic [76:0]   sel_msg;
    logic [76:0]   tagged_msg;
    logic          resp_deliver;
    logic          resp_fire;
    logic          tag_ok;

    // Credits count both requests already sent to memory and the one parked in qreg.
    assign mem_fire   = q_val & mem_req_rdy;
    assign inflight   = {1'b0, out_cnt} + {4'b0, q_val};
    assign can_accept = reset & (~q_val | mem_fire) & (inflight < 5'(MAX_OUT));

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant    = '0;
        any_val  = 1'b0;
        scan_idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = (int'(ptr) + k) % NREQ;
            if (req_val[scan_idx]) begin
                grant   = IW'(scan_idx);
                any_val = 1'b1;
            end
        end
    end

    always_comb begin
        sel_msg    = req_msg[int'(grant)*77 +: 77];
        tagged_msg = {sel_msg[76:74], 8'(grant), sel_msg[65:0]};
    end

    assign req_fire    = can_accept & any_val;
    assign req_rdy     = req_fire ? (NREQ'(1) << grant) : '0;
    assign mem_req_val = q_val;
    assign mem_req_msg = qreg;

    assign resp_deliver = r_val & resp_rdy[r_dest];
    assign mem_resp_rdy = reset & (~r_val | resp_deliver);
    assign resp_fire    = mem_resp_val & mem_resp_rdy;
    assign tag_ok       = mem_resp_msg[43:36] < 8'(NREQ);
    assign resp_val     = r_val ? (NREQ'(1) << r_dest) : '0;
    assign resp_msg     = {NREQ{rreg}};

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr     <= '0;
            q_val   <= 1'b0;
            out_cnt <= '0;
            r_val   <= 1'b0;
            r_dest  <= '0;
            tag_err <= 1'b0;
        end else begin
            if (req_fire) begin
                ptr   <= IW'((int'(grant) + 1) % NREQ);
                q_val <= 1'b1;
            end else if (mem_fire) begin
                q_val <= 1'b0;
            end

            if (mem_fire && !resp_fire)
                out_cnt <= out_cnt + 4'd1;
            else if (resp_fire && !mem_fire && out_cnt != 4'd0)
                out_cnt <= out_cnt - 4'd1;

            if (resp_fire && tag_ok) begin
                r_val  <= 1'b1;
                r_dest <= IW'(mem_resp_msg[43:36]);
            end else if (resp_deliver) begin
                r_val <= 1'b0;
            end

            if (resp_fire && !tag_ok)
                tag_err <= 1'b1;
        end
    end

    // NOTE: payload registers are qualified by their valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        if (req_fire)
            qreg <= tagged_msg;
        if (resp_fire && tag_ok)
            rreg <= {mem_resp_msg[46:44], 8'd0, mem_resp_msg[35:0]};
    end

`ifdef PAGERANK_MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (req_fire)
                grant_cnt <= grant_cnt + 32'd1;
            if (|req_val && !can_accept)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pagerank_mem_arbiter.sv
// Self-checking bench for pagerank_mem_arbiter: directed scenarios followed by a
// randomized phase checked against a queue-based transaction model.
module tb_pagerank_mem_arbiter;

    localparam int NREQ    = 4;
    localparam int MAX_OUT = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ*77-1:0]  req_msg;
    logic [NREQ-1:0]     req_val;
    logic [NREQ-1:0]     req_rdy;
    logic [NREQ*47-1:0]  resp_msg;
    logic [NREQ-1:0]     resp_val;
    logic [NREQ-1:0]     resp_rdy;
    logic [76:0]         mem_req_msg;
    logic                mem_req_val;
    logic                mem_req_rdy;
    logic [46:0]         mem_resp_msg;
    logic                mem_resp_val;
    logic                mem_resp_rdy;
    logic                tag_err;
`ifdef PAGERANK_MEM_ARB_PERF_EN
    logic [31:0]         grant_cnt;
    logic [31:0]         stall_cnt;
`endif

    pagerank_mem_arbiter #(.NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_msg      (req_msg),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .resp_msg     (resp_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_resp_msg (mem_resp_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
        .tag_err      (tag_err)
`ifdef PAGERANK_MEM_ARB_PERF_EN
        ,
        .grant_cnt    (grant_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [76:0] obs, input logic [76:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] addr, input logic [1:0] len,
                                           input logic [31:0] data);
        return {t, op, addr, len, data};
    endfunction

    function automatic logic [46:0] mk_resp(input logic [2:0] t, input logic [7:0] op,
                                            input logic [1:0] tst, input logic [1:0] len,
                                            input logic [31:0] data);
        return {t, op, tst, len, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        req_val      = '0;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        resp_rdy     = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Model state for the randomized phase
    logic [76:0]   acc_q[$];
    logic [76:0]   mem_q[$];
    logic [46:0]   del_q[$];
    int            del_dest_q[$];
    int            rr;
    int            outst;
    int            model_grants;
    int            model_stalls;
    int            fires;
    int            exp_g;
    int            idx;
    bit            allowed;
    bit            exp_mem_fire;
    bit            exp_deliver;
    bit            exp_mresp_rdy;
    bit            exp_resp_fire;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rval;
    logic [76:0]   m;
    logic [76:0]   r;
    logic [46:0]   rs;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values, with requests asserted to prove ready is held low
        reset        = 1'b0;
        req_msg      = '0;
        req_val      = '1;
        mem_req_rdy  = 1'b1;
        mem_resp_val = 1'b0;
        mem_resp_msg = '0;
        resp_rdy     = '1;
        #2;
        check("rst_req_rdy", req_rdy, 0);
        check("rst_mem_req_val", mem_req_val, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_mem_resp_rdy", mem_resp_rdy, 0);
        check("rst_tag_err", tag_err, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        req_val = '0;

        // Single request and its response
        req_msg[0 +: 77] = mk_req(3'd0, 8'h55, 32'h100, 2'd0, 32'h1234);
        req_val = 4'b0001;
        #1 check("t1_req_rdy", req_rdy, 4'b0001);
        tick();
        req_val = '0;
        #1 check("t1_mem_val", mem_req_val, 1);
        check("t1_mem_msg", mem_req_msg, mk_req(3'd0, 8'd0, 32'h100, 2'd0, 32'h1234));
        tick();
        check("t1_mem_val_clr", mem_req_val, 0);
        mem_resp_msg = mk_resp(3'd0, 8'd0, 2'd0, 2'd0, 32'hDEAD);
        mem_resp_val = 1'b1;
        #1 check("t1_mem_resp_rdy", mem_resp_rdy, 1);
        tick();
        mem_resp_val = 1'b0;
        #1 check("t1_resp_val", resp_val, 4'b0001);
        check("t1_resp_msg0", resp_msg[0 +: 47], mk_resp(3'd0, 8'd0, 2'd0, 2'd0, 32'hDEAD));
        check("t1_resp_msg2", resp_msg[94 +: 47], mk_resp(3'd0, 8'd0, 2'd0, 2'd0, 32'hDEAD));
        tick();
        check("t1_resp_val_clr", resp_val, 0);

        // Round-robin with all requesters active; responses keep credits free
        do_reset();
        for (int i = 0; i < NREQ; i++)
            req_msg[i*77 +: 77] = mk_req(3'd1, 8'hFF, 32'h1000 + i, 2'd2, 32'hA0 + i);
        req_val      = '1;
        mem_req_rdy  = 1'b1;
        resp_rdy     = '1;
        mem_resp_msg = mk_resp(3'd1, 8'd0, 2'd0, 2'd0, 32'd0);
        mem_resp_val = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_rdy = NREQ'(1 << (k % 4));
            check("rr_grant", req_rdy, exp_rdy);
            if (k > 0) begin
                idx = (k - 1) % 4;
                check("rr_msg", mem_req_msg, mk_req(3'd1, 8'(idx), 32'h1000 + idx, 2'd2, 32'hA0 + idx));
            end
            tick();
        end
        req_val      = '0;
        mem_resp_val = 1'b0;

        // Credit cap with no responses returned
        do_reset();
        req_val     = '1;
        mem_req_rdy = 1'b1;
        fires       = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (req_rdy != 0) fires++;
            tick();
        end
        check("cap_fires", 77'(fires), 4);
        mem_resp_msg = mk_resp(3'd0, 8'd0, 2'd0, 2'd0, 32'h1);
        mem_resp_val = 1'b1;
        resp_rdy     = '1;
        #1 check("cap_same_cycle", req_rdy, 0);
        check("cap_resp_rdy", mem_resp_rdy, 1);
        tick();
        mem_resp_val = 1'b0;
        #1 check("cap_freed", req_rdy, 4'b0001);
        tick();
        check("cap_again", req_rdy, 0);
        req_val = '0;

        // Memory back-pressure holds qreg and the pointer
        do_reset();
        mem_req_rdy = 1'b0;
        req_val     = '1;
        #1 check("bp_first", req_rdy, 4'b0001);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_stall", req_rdy, 0);
            check("bp_val", mem_req_val, 1);
            check("bp_msg_stable", mem_req_msg, mk_req(3'd1, 8'd0, 32'h1000, 2'd2, 32'hA0));
            tick();
        end
        mem_req_rdy = 1'b1;
        #1 check("bp_ptr", req_rdy, 4'b0010);
        tick();
        req_val = '0;
        tick();

        // Out-of-range response tag
        do_reset();
        resp_rdy     = '1;
        mem_resp_msg = mk_resp(3'd0, 8'd7, 2'd0, 2'd0, 32'hBAD);
        mem_resp_val = 1'b1;
        #1 check("bad_resp_rdy", mem_resp_rdy, 1);
        tick();
        mem_resp_val = 1'b0;
        #1 check("bad_no_val", resp_val, 0);
        check("bad_tag_err", tag_err, 1);
        repeat (3) tick();
        check("bad_sticky", tag_err, 1);

        // Reset while both registers hold traffic
        do_reset();
        check("mid_tag_err_clr", tag_err, 0);
        mem_req_rdy = 1'b0;
        req_val     = 4'b0001;
        tick();
        req_val      = '0;
        mem_resp_msg = mk_resp(3'd0, 8'd1, 2'd0, 2'd0, 32'h77);
        mem_resp_val = 1'b1;
        resp_rdy     = '0;
        tick();
        mem_resp_val = 1'b0;
        #1 check("mid_q_valid", mem_req_val, 1);
        check("mid_r_valid", resp_val, 4'b0010);
        reset   = 1'b0;
        req_val = 4'b0100;
        #1 check("mid_rst_mem_val", mem_req_val, 0);
        check("mid_rst_resp_val", resp_val, 0);
        check("mid_rst_req_rdy", req_rdy, 0);
        check("mid_rst_resp_rdy", mem_resp_rdy, 0);
        tick();
        reset       = 1'b1;
        resp_rdy    = '1;
        mem_req_rdy = 1'b1;
        #1 check("rel_grant2", req_rdy, 4'b0100);
        tick();
        req_val = '0;
        #1 check("rel_mem_val", mem_req_val, 1);
        check("rel_mem_msg", mem_req_msg, mk_req(3'd1, 8'd2, 32'h1002, 2'd2, 32'hA2));
        tick();

        // Randomized traffic against the transaction model
        do_reset();
        rr = 0; outst = 0; model_grants = 0; model_stalls = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_val[i] && $urandom_range(0, 2) == 0) begin
                    req_msg[i*77 +: 77] = mk_req(3'($urandom), 8'($urandom), $urandom, 2'($urandom), $urandom);
                    req_val[i] = 1'b1;
                end
            end
            mem_req_rdy = ($urandom_range(0, 9) < 7);
            if (!mem_resp_val && mem_q.size() > 0 && $urandom_range(0, 1) == 0) begin
                r = mem_q.pop_front();
                mem_resp_msg = mk_resp(3'($urandom), r[73:66], 2'($urandom), r[33:32], r[31:0] ^ r[65:34]);
                mem_resp_val = 1'b1;
            end
            for (int i = 0; i < NREQ; i++)
                resp_rdy[i] = ($urandom_range(0, 4) != 0);
            #1;

            exp_mem_fire = (acc_q.size() > 0) && mem_req_rdy;
            allowed = ((acc_q.size() == 0) || exp_mem_fire) && (outst + acc_q.size() < MAX_OUT);
            exp_g = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (rr + k) % NREQ;
                if (req_val[idx] && exp_g < 0) exp_g = idx;
            end
            exp_rdy = (allowed && exp_g >= 0) ? NREQ'(1 << exp_g) : '0;
            check("rnd_req_rdy", req_rdy, exp_rdy);
            check("rnd_mem_val", mem_req_val, 77'(acc_q.size() > 0));
            if (acc_q.size() > 0)
                check("rnd_mem_msg", mem_req_msg, acc_q[0]);
            exp_rval = (del_q.size() > 0) ? NREQ'(1 << del_dest_q[0]) : '0;
            check("rnd_resp_val", resp_val, exp_rval);
            if (del_q.size() > 0)
                check("rnd_resp_msg", resp_msg[del_dest_q[0]*47 +: 47], del_q[0]);
            exp_deliver   = (del_q.size() > 0) && resp_rdy[del_dest_q[0]];
            exp_mresp_rdy = (del_q.size() == 0) || exp_deliver;
            check("rnd_mem_resp_rdy", mem_resp_rdy, 77'(exp_mresp_rdy));
            exp_resp_fire = mem_resp_val && exp_mresp_rdy;

            if (req_val != 0 && !allowed) model_stalls++;
            if (exp_mem_fire) mem_q.push_back(acc_q.pop_front());
            if (exp_rdy != 0) begin
                m = req_msg[exp_g*77 +: 77];
                m[73:66] = 8'(exp_g);
                acc_q.push_back(m);
                rr = (exp_g + 1) % NREQ;
                model_grants++;
            end
            if (exp_deliver) begin
                void'(del_q.pop_front());
                void'(del_dest_q.pop_front());
            end
            if (exp_resp_fire && mem_resp_msg[43:36] < NREQ) begin
                rs = mem_resp_msg;
                rs[43:36] = 8'd0;
                del_q.push_back(rs);
                del_dest_q.push_back(int'(mem_resp_msg[43:36]));
            end
            if (exp_mem_fire && !exp_resp_fire) outst++;
            else if (exp_resp_fire && !exp_mem_fire && outst > 0) outst--;

            tick();
            if (exp_rdy != 0) req_val[exp_g] = 1'b0;
            if (exp_resp_fire) mem_resp_val = 1'b0;
        end
        check("rnd_tag_err", tag_err, 0);
`ifdef PAGERANK_MEM_ARB_PERF_EN
        check("perf_grant_cnt", grant_cnt, 77'(model_grants));
        check("perf_stall_cnt", stall_cnt, 77'(model_stalls));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
